// File: rtl/pipe_ctrl.sv
// Pipeline hazard/branch controller: tracks EX and WB destinations, stalls on RAW hazards
// and flushes for FLUSH_CYCLES cycles when a branch resolves taken in EX.
module pipe_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned WB_BYPASS    = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [5:0]  id_rs,
   input  logic [5:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_regWrite,
   input  logic [5:0]  id_rd,
   input  logic [1:0]  id_branch,
   input  logic        zero,
   input  logic        neg,
   output logic        stall,
   output logic        flush,
   output logic        pc_sel,
   output logic        issue,
   output logic [1:0]  state,
   output logic [15:0] stall_count
);

   typedef enum logic [1:0] {StRun = 2'b00, StStall = 2'b01, StFlush = 2'b10} state_e;

   localparam logic [1:0] FlushLoad = 2'(FLUSH_CYCLES - 1);
   localparam logic       UseWb     = (WB_BYPASS == 0);

   state_e      state_q;
   logic        ex_valid_q, ex_rw_q;
   logic [5:0]  ex_rd_q;
   logic [1:0]  ex_br_q;
   // The WB slot's branch field is never consulted, so it is not stored.
   logic        wb_valid_q, wb_rw_q;
   logic [5:0]  wb_rd_q;
   logic [1:0]  flush_cnt_q;
   logic [15:0] stall_cnt_q;

   logic ex_wr, wb_wr, rs_hit, rt_hit, hazard, taken, in_flush;

   assign ex_wr  = ex_valid_q & ex_rw_q;
   assign wb_wr  = wb_valid_q & wb_rw_q & UseWb;
   assign rs_hit = id_uses_rs & ((ex_wr & (ex_rd_q == id_rs)) | (wb_wr & (wb_rd_q == id_rs)));
   assign rt_hit = id_uses_rt & ((ex_wr & (ex_rd_q == id_rt)) | (wb_wr & (wb_rd_q == id_rt)));
   assign hazard = id_valid & (rs_hit | rt_hit);

   assign taken = ex_valid_q & ((ex_br_q == 2'b11) |
                                ((ex_br_q == 2'b01) & zero) |
                                ((ex_br_q == 2'b10) & neg));

   assign in_flush = (state_q == StFlush);

   // Outputs are forced low while reset is held, independent of the ID inputs.
   assign pc_sel      = ~reset & taken;
   assign flush       = ~reset & (taken | (in_flush & (flush_cnt_q != 2'd0)));
   assign stall       = ~reset & hazard & ~taken & ~in_flush;
   assign issue       = ~reset & id_valid & ~stall & ~flush;
   assign state       = state_q;
   assign stall_count = stall_cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StRun;
         ex_valid_q  <= 1'b0;
         ex_rw_q     <= 1'b0;
         ex_rd_q     <= 6'd0;
         ex_br_q     <= 2'b00;
         wb_valid_q  <= 1'b0;
         wb_rw_q     <= 1'b0;
         wb_rd_q     <= 6'd0;
         flush_cnt_q <= 2'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         ex_valid_q <= issue;
         ex_rw_q    <= issue & id_regWrite;
         ex_rd_q    <= issue ? id_rd : 6'd0;
         ex_br_q    <= issue ? id_branch : 2'b00;
         wb_valid_q <= ex_valid_q;
         wb_rw_q    <= ex_rw_q;
         wb_rd_q    <= ex_rd_q;

         if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end

         unique case (state_q)
            StRun: begin
               if (taken) begin
                  state_q     <= StFlush;
                  flush_cnt_q <= FlushLoad;
               end else if (hazard) begin
                  state_q <= StStall;
               end
            end
            StStall: begin
               if (taken) begin
                  state_q     <= StFlush;
                  flush_cnt_q <= FlushLoad;
               end else if (!hazard) begin
                  state_q <= StRun;
               end
            end
            StFlush: begin
               if (flush_cnt_q <= 2'd1) begin
                  state_q <= StRun;
               end
               if (flush_cnt_q != 2'd0) begin
                  flush_cnt_q <= flush_cnt_q - 2'd1;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: one instance with the WB slot compared, one with write-before-read,
// driven in lockstep from a vector table through a scoreboard queue, plus directed sequences.
module tb_pipe_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_valid, id_uses_rs, id_uses_rt, id_regWrite, zero, neg;
   logic [5:0]  id_rs, id_rt, id_rd;
   logic [1:0]  id_branch;

   logic        stall0, flush0, pc0, issue0, stall1, flush1, pc1, issue1;
   logic [1:0]  state0, state1;
   logic [15:0] cnt0, cnt1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   pipe_ctrl u_dut0 (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regWrite(id_regWrite),
      .id_rd(id_rd), .id_branch(id_branch), .zero(zero), .neg(neg),
      .stall(stall0), .flush(flush0), .pc_sel(pc0), .issue(issue0), .state(state0),
      .stall_count(cnt0)
   );

   pipe_ctrl #(.WB_BYPASS(1)) u_dut1 (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regWrite(id_regWrite),
      .id_rd(id_rd), .id_branch(id_branch), .zero(zero), .neg(neg),
      .stall(stall1), .flush(flush1), .pc_sel(pc1), .issue(issue1), .state(state1),
      .stall_count(cnt1)
   );

   typedef struct {
      logic        idv;
      logic [5:0]  rs, rt;
      logic        urs, urt, rw;
      logic [5:0]  rd;
      logic [1:0]  br;
      logic        z, n;
      logic        s0, i0;
      logic [1:0]  st0;
      logic        s1, i1;
      logic [1:0]  st1;
      logic        f, p;
      logic [15:0] c0, c1;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic idv, input logic [5:0] rs, input logic [5:0] rt,
                      input logic urs, input logic urt, input logic rw, input logic [5:0] rd,
                      input logic [1:0] br, input logic z, input logic n,
                      input logic s0, input logic i0, input logic [1:0] st0,
                      input logic s1, input logic i1, input logic [1:0] st1,
                      input logic f, input logic p, input logic [15:0] c0,
                      input logic [15:0] c1);
      vec_t v;
      v.idv = idv; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.rw = rw; v.rd = rd;
      v.br = br; v.z = z; v.n = n; v.s0 = s0; v.i0 = i0; v.st0 = st0; v.s1 = s1;
      v.i1 = i1; v.st1 = st1; v.f = f; v.p = p; v.c0 = c0; v.c1 = c1;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic idv, input logic [5:0] rs, input logic [5:0] rt,
                        input logic urs, input logic urt, input logic rw, input logic [5:0] rd,
                        input logic [1:0] br, input logic z, input logic n);
      id_valid = idv; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_regWrite = rw; id_rd = rd; id_branch = br; zero = z; neg = n;
   endtask

   task automatic idle(input logic [15:0] c0, input logic [15:0] c1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c0, c1);
   endtask

   task automatic chk_all_zero(input string tag);
      cmp({tag, " stall0"}, 16'(stall0), 16'd0);
      cmp({tag, " flush0"}, 16'(flush0), 16'd0);
      cmp({tag, " pc_sel0"}, 16'(pc0), 16'd0);
      cmp({tag, " issue0"}, 16'(issue0), 16'd0);
      cmp({tag, " state0"}, 16'(state0), 16'd0);
      cmp({tag, " count0"}, cnt0, 16'd0);
      cmp({tag, " issue1"}, 16'(issue1), 16'd0);
      cmp({tag, " flush1"}, 16'(flush1), 16'd0);
      cmp({tag, " state1"}, 16'(state1), 16'd0);
      cmp({tag, " count1"}, cnt1, 16'd0);
   endtask

   initial begin
      vec_t v, e;

      // Independent stream: sources r1/r2 never match destinations r10..r19.
      for (int k = 0; k < 10; k++) begin
         add(1, 1, 2, 1, 1, 1, 6'(10 + k), 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      end
      idle(0, 0); idle(0, 0);
      // RAW on r5: two stalls with the WB compare, one with write-before-read.
      add(1, 1, 2, 1, 1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      add(1, 5, 0, 1, 0, 0, 7, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 5, 0, 1, 0, 0, 7, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1);
      add(1, 5, 0, 1, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 2, 1);
      idle(2, 1); idle(2, 1);
      // Branch-if-zero taken: pc_sel one cycle, flush two cycles.
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 1);
      add(1, 1, 2, 1, 1, 1, 20, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1);
      add(1, 1, 2, 1, 1, 1, 20, 0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 0, 2, 1);
      add(1, 1, 2, 1, 1, 1, 20, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 1);
      // Branch-if-zero not taken.
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 1);
      add(1, 1, 2, 1, 1, 1, 21, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 1);
      idle(2, 1); idle(2, 1);
      // Branch-if-neg taken while ID has a RAW on the branch's rd: taken wins.
      add(1, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 1);
      add(1, 9, 0, 1, 0, 0, 22, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1);
      add(1, 9, 0, 1, 0, 0, 22, 0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 0, 2, 1);
      add(1, 9, 0, 1, 0, 0, 22, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 1);
      idle(2, 1); idle(2, 1);

      // Reset state, with a valid ID instruction present.
      reset = 1'b1;
      drive(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
      #12;
      chk_all_zero("reset");
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         drive(v.idv, v.rs, v.rt, v.urs, v.urt, v.rw, v.rd, v.br, v.z, v.n);
         sb.push_back(v);
         @(negedge clock);
         e = sb.pop_front();
         cmp($sformatf("v%0d stall0", i), 16'(stall0), 16'(e.s0));
         cmp($sformatf("v%0d issue0", i), 16'(issue0), 16'(e.i0));
         cmp($sformatf("v%0d state0", i), 16'(state0), 16'(e.st0));
         cmp($sformatf("v%0d stall1", i), 16'(stall1), 16'(e.s1));
         cmp($sformatf("v%0d issue1", i), 16'(issue1), 16'(e.i1));
         cmp($sformatf("v%0d state1", i), 16'(state1), 16'(e.st1));
         cmp($sformatf("v%0d flush", i), 16'({flush0, flush1}), 16'({e.f, e.f}));
         cmp($sformatf("v%0d pc_sel", i), 16'({pc0, pc1}), 16'({e.p, e.p}));
         cmp($sformatf("v%0d count0", i), cnt0, e.c0);
         cmp($sformatf("v%0d count1", i), cnt1, e.c1);
         @(posedge clock);
         #1;
      end

      // Reset asserted in the second flush cycle of a jump.
      drive(1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
      @(posedge clock);
      #1;
      drive(1, 1, 2, 1, 1, 1, 30, 0, 0, 0);
      @(negedge clock);
      cmp("jump flush", 16'(flush0), 16'd1);
      cmp("jump pc_sel", 16'(pc0), 16'd1);
      @(posedge clock);
      #1;
      cmp("jump state", 16'(state0), 16'd2);
      cmp("jump flush2", 16'(flush0), 16'd1);
      reset = 1'b1;
      #1;
      chk_all_zero("midflush");
      @(posedge clock);
      #1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      cmp("post-reset issue0", 16'(issue0), 16'd1);
      cmp("post-reset issue1", 16'(issue1), 16'd1);
      cmp("post-reset state0", 16'(state0), 16'd0);
      cmp("post-reset flush0", 16'(flush0), 16'd0);
      cmp("post-reset stall0", 16'(stall0), 16'd0);
      @(posedge clock);
      #1;

      // Chain of r5 -> r5 dependences: 65536 stalls saturate one counter, 49152 for the other.
      drive(1, 5, 0, 1, 0, 1, 5, 0, 0, 0);
      repeat (98304) @(posedge clock);
      #1;
      id_valid = 1'b0;
      cmp("saturate count0", cnt0, 16'hFFFF);
      cmp("chain count1", cnt1, 16'hC000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
